key_matrix_scan: RTL
====================

# key_matrix_scan

Scanner for the 4x4 active-low push-button matrix on the board GPIO header. It is the input-side counterpart of the LED matrix multiplexer: it drives one column low at a time, senses the rows, and debounces each of the 16 keys. It then reports press/release events through a valid/ready handshake. It also provides a 4-bit active-low level vector that plugs directly into the existing paddle key logic.

## Interface
- SETTLE_CYCLES, 4: cycles each column stays driven; legal range 3..255.
- DEBOUNCE_SCANS, 3: consecutive differing samples needed to commit a key change; legal range 1..7.
- CLK  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- col_drv  output  4  column drive, one-hot active-low.
- row_sense  input  4  row sense, active-low (pulled up), asynchronous to CLK.
- keys_state  output  16  debounced level per key, 1 = pressed; index = row*4 + col.
- keys_n  output  4  ~keys_state[3:0]; drop-in for the paddle key input.
- key_valid  output  1  event pending.
- key_code  output  4  index of the key in the pending event.
- key_press  output  1  1 = press event, 0 = release event.
- key_ready  input  1  consumer accepts the event.

## Operation
- Synchronizer: row_sense passes through 2 flops before use. Both stages reset to 4'hF.
- Scan FSM: column index c (2 bits), settle counter s (8 bits).
  - col_drv = ~(1 << c).
  - s counts 0..SETTLE_CYCLES-1.
  - On s == SETTLE_CYCLES-1 (SAMPLE cycle): evaluate column c, set s = 0, then c = c+1 mod 4 (wraps 3 -> 0).
- Per-key debounce: 16 counters, 3 bits each. At SAMPLE, for each row r, key k = r*4 + c, raw = ~sync_row[r]:
  - raw == keys_state[k]: counter[k] = 0.
  - raw != keys_state[k] and counter[k] < DEBOUNCE_SCANS-1: counter[k] += 1.
  - raw != keys_state[k] and counter[k] >= DEBOUNCE_SCANS-1: the key is commit-eligible.
- Commit rule: one event slot, at most one commit per SAMPLE cycle.
  - The slot is free only when key_valid == 0 at that edge.
  - If the slot is free, the lowest eligible row commits: keys_state[k] toggles, counter[k] = 0, key_valid = 1, key_code = k, key_press = raw.
  - Eligible keys not committed hold their counter saturated at DEBOUNCE_SCANS-1. They retry on the next scan of their column, where one more differing sample suffices.
  - If the raw level returns to the debounced value before commit, the counter clears and no event is produced.
- keys_state and the event stream are always consistent: a level changes only together with its event.
- Handshake: key_valid, key_code and key_press hold stable until an edge with key_valid && key_ready. key_valid is 0 after that edge. key_ready is ignored while key_valid == 0.

## Timing
- Reset values:
  - col_drv = 4'b1110.
  - c = 0, s = 0.
  - keys_state = 0, keys_n = 4'hF.
  - key_valid = 0, key_code = 0, key_press = 0.
  - All debounce counters = 0, synchronizer = 4'hF.
- rst_n assertion clears everything immediately, including mid-event and mid-scan. After release, the scan restarts at column 0.
- Scan period = 4*SETTLE_CYCLES cycles.
- Sampled row data reflects row_sense from at least 2 cycles earlier. Because SETTLE_CYCLES >= 3, every sample is taken after at least 1 cycle of settling on the current column.
- Event latency from a stable press is at most (DEBOUNCE_SCANS+1) scan periods + 3 cycles, when the slot is free.
- key_valid, keys_state and keys_n update on the same edge: the SAMPLE edge.
- Acceptance and a new commit cannot happen on the same edge. The earliest re-fill is the next SAMPLE cycle after key_valid falls.

## Test plan
All scenarios use SETTLE_CYCLES=4 and DEBOUNCE_SCANS=3. The bench models the matrix: row_sense[r] = 0 iff key (r,c) is held and col_drv[c] = 0.
- Reset and scan:
  - Stimulus: release rst_n.
  - Required: col_drv = 1110 for 4 cycles, then 1101, 1011, 0111, then wraps to 1110 at cycle 16. All other outputs hold their reset values.
- Press with backpressure:
  - Stimulus: hold key 6 (row 1, col 2) with key_ready = 0.
  - Required: on the third column-2 SAMPLE, key_valid = 1, key_code = 6, key_press = 1, keys_state[6] = 1. These stay stable for 100 cycles. A 1-cycle key_ready pulse makes key_valid = 0 on the next cycle.
- Bounce rejection:
  - Stimulus: key 9 alternates held/released on successive scans for 4 scans, then stays held.
  - Required: no event during the bounce. Exactly one press event, code 9, on the third consecutive held sample.
- Same-column collision:
  - Stimulus: keys 2 and 14 pressed on the same cycle, key_ready tied 1.
  - Required: event code 2 first. Event code 14 on the next column-2 SAMPLE. keys_state[14] stays 0 until that edge.
- Release and legacy output:
  - Stimulus: press then release key 0.
  - Required: keys_n = 4'hE while the key is debounced-pressed. The release event has key_code = 0 and key_press = 0. keys_n returns to 4'hF on the same edge.
- Reset mid-event:
  - Stimulus: drop rst_n while key_valid = 1 and key 5 is held.
  - Required: all outputs at reset values immediately. After rst_n release, a fresh press event for code 5 arrives at the 3rd column-1 SAMPLE.

Source files
------------

// File: rtl/key_matrix_scan.sv
// 4x4 active-low key matrix scanner: one column driven low at a time, per-key
// debounce, single-slot press/release event queue with valid/ready handshake.
module key_matrix_scan #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic        CLK,
    input  logic        rst_n,
    output logic [3:0]  col_drv,
    input  logic [3:0]  row_sense,
    output logic [15:0] keys_state,
    output logic [3:0]  keys_n,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_press,
    input  logic        key_ready
);

    typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [2:0] DEB_LAST    = 3'(DEBOUNCE_SCANS - 1);

    logic [3:0]  sync1_reg, sync2_reg;
    col_t        col_reg, col_next;
    logic [7:0]  settle_reg, settle_next;
    logic        sample;

    logic [2:0]  cnt_reg  [16];
    logic [2:0]  cnt_next [16];
    logic [15:0] active, take, state_next;

    logic [3:0]  row_key [4];
    logic [3:0]  row_raw, row_diff, row_elig;
    logic        commit_en;
    logic [1:0]  commit_row;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 4'hF;
            sync2_reg <= 4'hF;
        end else begin
            sync1_reg <= row_sense;
            sync2_reg <= sync1_reg;
        end
    end

    // Scan sequencer: the column index is the state, the settle counter times it.
    assign sample = (settle_reg == SETTLE_LAST);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            col_reg    <= COL0;
            settle_reg <= '0;
        end else begin
            col_reg    <= col_next;
            settle_reg <= settle_next;
        end
    end

    always_comb begin
        col_next    = col_reg;
        settle_next = settle_reg + 8'd1;
        if (sample) begin
            settle_next = '0;
            col_next    = col_t'(col_reg + 2'd1);
        end
    end

    assign col_drv = ~(4'b0001 << col_reg);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign row_key[gi]  = {2'(gi), col_reg};
            assign row_raw[gi]  = ~sync2_reg[gi];
            assign row_diff[gi] = row_raw[gi] ^ keys_state[row_key[gi]];
            assign row_elig[gi] = sample && row_diff[gi] && (cnt_reg[row_key[gi]] >= DEB_LAST);
        end
    endgenerate

    // Lowest eligible row wins, and only when the event slot is empty.
    always_comb begin
        commit_en  = 1'b0;
        commit_row = '0;
        if (!key_valid) begin
            for (int r = 3; r >= 0; r--) begin
                if (row_elig[r]) begin
                    commit_en  = 1'b1;
                    commit_row = 2'(r);
                end
            end
        end
    end

    generate
        for (gi = 0; gi < 16; gi++) begin : g_key
            localparam int         R = gi / 4;
            localparam logic [1:0] C = 2'(gi % 4);

            assign active[gi] = sample && (col_reg == col_t'(C));
            assign take[gi]   = active[gi] && commit_en && (commit_row == 2'(R));

            // A losing eligible key parks at DEB_LAST so one more differing sample commits it.
            assign cnt_next[gi] = !active[gi]            ? cnt_reg[gi] :
                                  !row_diff[R]           ? 3'd0 :
                                  (cnt_reg[gi] < DEB_LAST) ? cnt_reg[gi] + 3'd1 :
                                  take[gi]               ? 3'd0 : DEB_LAST;

            always_ff @(posedge CLK or negedge rst_n) begin
                if (!rst_n) cnt_reg[gi] <= '0;
                else        cnt_reg[gi] <= cnt_next[gi];
            end
        end
    endgenerate

    assign state_next = keys_state ^ take;
    assign keys_n     = ~keys_state[3:0];

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            keys_state <= '0;
            key_valid  <= 1'b0;
            key_code   <= '0;
            key_press  <= 1'b0;
        end else begin
            keys_state <= state_next;
            if (!key_valid) begin
                if (commit_en) begin
                    key_valid <= 1'b1;
                    key_code  <= row_key[commit_row];
                    key_press <= row_raw[commit_row];
                end
            end else if (key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule
